// File: rtl/roller_pkg.sv
// roller_pkg: state encoding and default LFSR tap mask shared by the slot roller.
package roller_pkg;
  typedef enum logic [1:0] {IDLE, ROLL, STOPPING, DONE} state_t;
  // x^16 + x^14 + x^13 + x^11 + 1 -> taps at bits 15, 13, 12, 10
  localparam logic [15:0] TAP_MASK = 16'hB400;
endpackage

// File: rtl/roller_lfsr.sv
// roller_lfsr: left-shifting Fibonacci LFSR that reloads its seed if it ever locks up at zero.
module roller_lfsr #(
  parameter int W = 16,
  parameter int OUT_W = 12,
  parameter logic [W-1:0] SEED = W'(1),
  parameter logic [W-1:0] TAPS = W'(roller_pkg::TAP_MASK)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] sample
);
  logic [W-1:0] state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else state <= state == '0 ? SEED : {state[W-2:0], ^(state & TAPS)};
  assign sample = state[OUT_W-1:0];
endmodule

// File: rtl/random_slot_roller.sv
// random_slot_roller: N_CH pseudo-random value channels that roll on a divided tick
// and freeze one by one after stop, flagging a match when all land equal.
module random_slot_roller
  import roller_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int VAL_W = 4,
  parameter int MAX_VAL = 9,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'h0001,
  parameter int DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [N_CH-1:0]       hold,
  output logic [N_CH*VAL_W-1:0] val,
  output logic [N_CH-1:0]       frozen,
  output logic                  busy,
  output logic                  match,
  output logic                  tick
);
  localparam int CW = $clog2(DIV);
  localparam int KW = N_CH > 1 ? $clog2(N_CH) : 1;
  if (N_CH*VAL_W > LFSR_W || MAX_VAL >= 2**VAL_W || MAX_VAL+1 < 2**(VAL_W-1) || SEED == '0 || DIV < 2)
    begin : g_bad_params
      $error("random_slot_roller: illegal parameter set");
    end
  state_t state;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [N_CH*VAL_W-1:0] raw, nxt;
  logic all_eq;
  roller_lfsr #(.W(LFSR_W), .OUT_W(N_CH*VAL_W), .SEED(SEED), .TAPS(LFSR_W'(TAP_MASK))) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .sample(raw)
  );
  assign tick = cnt == CW'(DIV-1);
  // Single conditional subtract folds raw into 0..MAX_VAL since MAX_VAL+1 >= 2^(VAL_W-1)
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      nxt[i*VAL_W +: VAL_W] = raw[i*VAL_W +: VAL_W] > VAL_W'(MAX_VAL)
        ? raw[i*VAL_W +: VAL_W] - VAL_W'(MAX_VAL+1) : raw[i*VAL_W +: VAL_W];
      all_eq = all_eq & (val[i*VAL_W +: VAL_W] == val[VAL_W-1:0]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      k      <= '0;
      val    <= '0;
      frozen <= '0;
      busy   <= 1'b0;
      match  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      case (state)
        IDLE, DONE: if (start) begin
          state  <= ROLL;
          busy   <= 1'b1;
          frozen <= '0;
          match  <= 1'b0;
          k      <= '0;
        end
        ROLL: begin
          if (tick)
            for (int i = 0; i < N_CH; i++)
              if (!hold[i]) val[i*VAL_W +: VAL_W] <= nxt[i*VAL_W +: VAL_W];
          if (stop) state <= STOPPING;
        end
        STOPPING: if (tick) begin
          for (int i = 0; i < N_CH; i++)
            if (KW'(i) == k) frozen[i] <= 1'b1;
            else if (!frozen[i] && !hold[i]) val[i*VAL_W +: VAL_W] <= nxt[i*VAL_W +: VAL_W];
          k <= k + 1'b1;
          // Every other channel is already frozen here, so current values are final
          if (k == KW'(N_CH-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            match <= all_eq;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_random_slot_roller.sv
// tb_random_slot_roller: table vectors, directed corner sequences and random stimulus
// checked against a cycle-level behavioural model of the roller.
module tb_random_slot_roller;
  localparam int DIV = 4;
  localparam int SEED = 1;
  localparam int P_IDLE = 0, P_ROLL = 1, P_STOP = 2, P_DONE = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, tick, busy, match;
  logic [2:0] hold = '0, frozen;
  logic [11:0] val;
  int nchk = 0, npass = 0;
  int m_cnt, m_lfsr, m_phase, m_k;
  int m_val[3];
  bit [2:0] m_frz;
  bit m_match;
  random_slot_roller #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .val(val), .frozen(frozen), .busy(busy), .match(match), .tick(tick)
  );
  always #5 clk = ~clk;
  function automatic int lfsr_next(int s);
    int fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return s == 0 ? SEED : (((s << 1) & 'hFFFF) | fb);
  endfunction
  function automatic int roll_val(int ch);
    return ((m_lfsr >> (4*ch)) & 15) % 10;
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_lfsr = SEED; m_phase = P_IDLE; m_k = 0; m_frz = '0; m_match = 0;
    for (int i = 0; i < 3; i++) m_val[i] = 0;
  endtask
  task automatic model_step(input bit st, input bit sp, input bit [2:0] hd);
    bit tk = m_cnt == DIV-1;
    if (m_phase == P_IDLE || m_phase == P_DONE) begin
      if (st) begin m_phase = P_ROLL; m_frz = '0; m_match = 0; m_k = 0; end
    end else if (m_phase == P_ROLL) begin
      if (tk) for (int i = 0; i < 3; i++) if (!hd[i]) m_val[i] = roll_val(i);
      if (sp) m_phase = P_STOP;
    end else if (tk) begin
      for (int i = 0; i < 3; i++)
        if (i == m_k) m_frz[i] = 1;
        else if (!m_frz[i] && !hd[i]) m_val[i] = roll_val(i);
      m_k++;
      if (m_k == 3) begin
        m_phase = P_DONE;
        m_match = m_val[0] == m_val[1] && m_val[1] == m_val[2];
      end
    end
    m_cnt = (m_cnt + 1) % DIV;
    m_lfsr = lfsr_next(m_lfsr);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  task automatic chk_model(input string nm);
    logic [11:0] ev;
    for (int i = 0; i < 3; i++) ev[i*4 +: 4] = 4'(m_val[i]);
    chk(nm, {val, frozen, busy, match, tick},
        {ev, m_frz, m_phase == P_ROLL || m_phase == P_STOP, m_match, m_cnt == DIV-1});
  endtask
  task automatic step(input bit st, input bit sp, input bit [2:0] hd);
    start = st; stop = sp; hold = hd;
    @(posedge clk);
    model_step(st, sp, hd);
    #1;
    start = 0; stop = 0;
  endtask
  task automatic do_reset();
    rst_n = 0; start = 0; stop = 0; hold = '0;
    #1;
    model_reset();
    chk("reset_outputs", {val, frozen, busy, match, tick}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  typedef struct packed {bit st; bit sp; bit [2:0] hd; bit tk; bit bz; bit [2:0] fz;} vec_t;
  vec_t tbl[18];
  initial begin
    tbl[0]  = '{1,0,3'b000,0,1,3'b000};
    tbl[1]  = '{0,0,3'b010,0,1,3'b000};
    tbl[2]  = '{0,0,3'b010,1,1,3'b000};
    tbl[3]  = '{0,1,3'b010,0,1,3'b000};
    tbl[4]  = '{0,0,3'b000,0,1,3'b000};
    tbl[5]  = '{0,0,3'b000,0,1,3'b000};
    tbl[6]  = '{0,0,3'b001,1,1,3'b000};
    tbl[7]  = '{0,0,3'b001,0,1,3'b001};
    tbl[8]  = '{0,0,3'b000,0,1,3'b001};
    tbl[9]  = '{0,0,3'b000,0,1,3'b001};
    tbl[10] = '{0,0,3'b100,1,1,3'b001};
    tbl[11] = '{0,0,3'b100,0,1,3'b011};
    tbl[12] = '{0,1,3'b000,0,1,3'b011};
    tbl[13] = '{1,0,3'b000,0,1,3'b011};
    tbl[14] = '{0,0,3'b000,1,1,3'b011};
    tbl[15] = '{0,0,3'b000,0,0,3'b111};
    tbl[16] = '{1,0,3'b000,0,1,3'b000};
    tbl[17] = '{1,1,3'b000,0,1,3'b000};
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step(0, 0, 0);
      chk("idle_tick", {31'd0, tick}, {31'd0, c % 4 == 3});
      chk_model("idle_model");
    end
    for (int r = 0; r < 18; r++) begin
      step(tbl[r].st, tbl[r].sp, tbl[r].hd);
      chk($sformatf("tbl_row%0d", r), {tick, busy, frozen}, {tbl[r].tk, tbl[r].bz, tbl[r].fz});
      chk_model($sformatf("tbl_model%0d", r));
    end
    step(0, 0, 0);
    step(0, 0, 0);
    chk("stop_partial", {29'd0, frozen}, 32'b001);
    do_reset();
    step(0, 0, 0);
    chk_model("post_reset_idle");
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    begin
      logic [3:0] v1;
      step(1, 0, 0);
      repeat (8) step(0, 0, 0);
      v1 = val[7:4];
      repeat (32) begin
        step(0, 0, 3'b010);
        chk_model("hold_model");
      end
      chk("hold_ch1_const", {28'd0, val[7:4]}, {28'd0, v1});
    end
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'b000);
      chk_model("random_model");
    end
    do_reset();
    step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    begin
      int n = 0;
      while (!(m_val[0] == m_val[1] && m_val[1] == m_val[2]) && n < 3000) begin
        step(0, 0, {m_val[2] == m_val[0], m_val[1] == m_val[0], 1'b1});
        n++;
      end
      chk("equalize_bound", {31'd0, n < 3000}, 32'd1);
      step(0, 1, 3'b111);
      n = 0;
      while (m_phase != P_DONE && n < 40) begin
        step(0, 0, 3'b111);
        chk_model("equal_stop_model");
        n++;
      end
      chk("done_bound", {31'd0, n < 40}, 32'd1);
    end
    chk("match_equal", {28'd0, busy, match, frozen}, {28'd0, 5'b01111});
    step(1, 0, 0);
    chk("restart_clears", {27'd0, busy, match, frozen}, {27'd0, 5'b10000});
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/random_slot_roller.md
RANDOM_SLOT_ROLLER -- requirements
Module: random_slot_roller

Interface
REQ-001 Parameter N_CH, default 3, number of independent value channels.
REQ-002 Parameter VAL_W, default 4, bit width of each channel value.
REQ-003 Parameter MAX_VAL, default 9, largest value any channel may show.
REQ-004 Parameter LFSR_W, default 16, LFSR register width.
REQ-005 Parameter SEED, default 16'h0001, LFSR reset value; must be nonzero.
REQ-006 Parameter DIV, default 100_000, clk cycles per roll tick; DIV >= 2.
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle request to begin rolling.
REQ-010 stop  input  1  one-cycle request to begin sequential stopping.
REQ-011 hold  input  N_CH  per-channel manual hold; 1 = channel does not update.
REQ-012 val  output  N_CH*VAL_W  packed channel values; channel i at [i*VAL_W +: VAL_W].
REQ-013 frozen  output  N_CH  per-channel frozen flag.
REQ-014 busy  output  1  high in ROLL and STOPPING.
REQ-015 match  output  1  high in DONE when all channel values are equal.
REQ-016 tick  output  1  one-cycle roll-tick strobe.

Function
REQ-017 Tick counter SHALL count 0..DIV-1 free-running in all states, wrap to 0; tick = 1 in the cycle counter == DIV-1; no derived clocks.
REQ-018 LFSR SHALL shift left every clk cycle, feedback = XOR of taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10); all-zero state SHALL reload SEED next cycle.
REQ-019 Raw sample for channel i SHALL be lfsr[i*VAL_W +: VAL_W] as registered in the tick cycle.
REQ-020 Channel update value SHALL be raw if raw <= MAX_VAL, else raw - (MAX_VAL+1); result always in 0..MAX_VAL.
REQ-021 FSM states: IDLE, ROLL, STOPPING, DONE.
REQ-022 IDLE or DONE: start -> ROLL next cycle; frozen cleared to 0, match cleared, stop pointer k = 0.
REQ-023 ROLL: on tick, every channel with hold[i]=0 loads its update value; held channels keep value.
REQ-024 ROLL: stop -> STOPPING next cycle; start ignored.
REQ-025 STOPPING: on each tick, channel k sets frozen[k] without updating; other non-frozen, non-held channels update; k increments.
REQ-026 STOPPING: when frozen[N_CH-1] sets, FSM enters DONE next cycle; start and stop ignored.
REQ-027 DONE entry: match registered = 1 iff all N_CH values equal; held until leaving DONE.
REQ-028 Frozen channels SHALL never update regardless of hold.
REQ-029 start and stop in same cycle: start acts in IDLE/DONE, stop acts in ROLL.
REQ-030 Values update exactly one cycle after the tick cycle; latency start -> first possible value change <= DIV+1 cycles.
REQ-031 busy and match SHALL be registered outputs.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, val all 0, frozen 0, match 0, busy 0, tick 0, counter 0, lfsr SEED, k 0.
REQ-033 Reset asserted mid-roll or mid-stop SHALL abandon operation; no partial freeze survives.
REQ-034 Reset release SHALL be synchronous to clk; first tick after release at cycle DIV-1.

Structure
REQ-035 Shared package roller_pkg SHALL hold the state enum and default tap mask constant.
REQ-036 Static elaboration checks: N_CH*VAL_W <= LFSR_W, MAX_VAL < 2^VAL_W, MAX_VAL+1 >= 2^(VAL_W-1), SEED != 0.
REQ-037 One sub-module roller_lfsr (parametrised LFSR with lockup recovery) SHALL be instantiated; rest inline.

Verification (bench DIV=4, defaults otherwise)
REQ-038 Reset, no start for 40 cycles -> val=0, frozen=0, busy=0, tick every 4th cycle.
REQ-039 start, then 10 ticks, hold=0 -> every val in 0..9, changes only the cycle after tick, matches reference LFSR model.
REQ-040 ROLL with hold=3'b010 for 8 ticks -> channel 1 constant, channels 0 and 2 follow model.
REQ-041 stop in ROLL -> frozen goes 001, 011, 111 on consecutive ticks, DONE next cycle, busy=0, match per equality.
REQ-042 Force equal values (model-selected SEED) -> match=1 in DONE; start -> match=0, frozen=0 next cycle.
REQ-043 rst_n low during STOPPING with frozen=3'b001 -> all outputs zero immediately, IDLE after release.
